// File: rtl/dev_capture.sv
`default_nettype none
// ============================================================================
//  Module   : dev_capture
//  Purpose  : Input-capture peripheral. Measures the period and high time of
//             an external signal from 1T edge pulses, counting ticks from a
//             prescaled system clock. Raises capture and timeout interrupts.
//  Ports    : clk, reset        - system clock, synchronous active-high reset
//             io_risen/fallen   - 1T edge pulses from the pin synchroniser
//             int_capture       - 1-cycle pulse after a period capture
//             int_timeout       - 1-cycle pulse after a counter timeout
//             we, addr, dtw,
//             stb, dtr, ack     - 4-word peripheral register port
//  Registers: 0 cfg[5:0], 1 period (RO), 2 high_width (RO), 3 status (W1C)
//  Revision : 1.0 - initial release
// ============================================================================
module dev_capture #(
  parameter int CAP_BITS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_risen,
  input  logic        io_fallen,
  output logic        int_capture,
  output logic        int_timeout,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] dtw,
  output logic [31:0] dtr,
  input  logic        stb,
  output logic        ack
);

  localparam logic [CAP_BITS-1:0] CNT_MAX = {CAP_BITS{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [5:0]          cfg_q, cfg_d;
  logic [CAP_BITS-1:0] period_q, period_d;
  logic [CAP_BITS-1:0] high_width_q, high_width_d;
  logic [CAP_BITS-1:0] counter_q, counter_d;
  logic [3:0]          status_q, status_d;
  logic [9:0]          div_q, div_d;
  logic                int_capture_q, int_capture_d;
  logic                int_timeout_q, int_timeout_d;

  logic                tick;
  logic                enabled;
  logic                edge_r, edge_f;
  logic                r_only, f_only, glitch;
  logic                cfg_wr, status_wr;
  logic                cap_evt, to_evt;
  logic [3:0]          status_set;
  logic [CAP_BITS-1:0] cnt_inc;
  logic                unused_dtw;

  assign unused_dtw = ^dtw[31:6];
  assign ack        = 1'b1;

  assign cfg_wr    = we && stb && (addr == 2'd0);
  assign status_wr = we && stb && (addr == 2'd3);

  // Tick source: prescaler taps on an all-ones low field of the divider.
  always_comb begin
    tick    = 1'b0;
    enabled = 1'b1;
    case (cfg_q[2:0])
      3'd1:    tick = 1'b1;
      3'd2:    tick = &div_q[2:0];
      3'd3:    tick = &div_q[5:0];
      3'd4:    tick = &div_q[7:0];
      3'd5:    tick = &div_q[9:0];
      default: enabled = 1'b0;
    endcase
  end

  // Invert swaps which pin edge starts the "high" phase.
  assign edge_r = cfg_q[5] ? io_fallen : io_risen;
  assign edge_f = cfg_q[5] ? io_risen  : io_fallen;
  assign glitch = edge_r && edge_f;
  assign r_only = edge_r && !edge_f;
  assign f_only = edge_f && !edge_r;

  // Saturating counter + tick; the counter never wraps.
  assign cnt_inc = (counter_q == CNT_MAX) ? CNT_MAX
                                          : counter_q + {{(CAP_BITS-1){1'b0}}, tick};

  always_comb begin
    state_d      = state_q;
    cfg_d        = cfg_q;
    period_d     = period_q;
    high_width_d = high_width_q;
    counter_d    = counter_q;
    div_d        = div_q + 10'd1;
    cap_evt      = 1'b0;
    to_evt       = 1'b0;
    status_set   = 4'd0;

    if (cfg_wr) begin
      // A configuration write restarts the measurement from scratch.
      cfg_d     = dtw[5:0];
      div_d     = 10'd0;
      state_d   = IDLE;
      counter_d = '0;
    end else if (!enabled) begin
      state_d   = IDLE;
      counter_d = '0;
    end else begin
      if (glitch) status_set[3] = 1'b1;
      case (state_q)
        IDLE: begin
          counter_d = '0;
          if (r_only) state_d = HIGH;
        end
        HIGH, LOW: begin
          counter_d = cnt_inc;
          if (r_only) begin
            // Also covers a missed fall while HIGH: capture and stay HIGH.
            period_d      = cnt_inc;
            counter_d     = '0;
            cap_evt       = 1'b1;
            status_set[0] = 1'b1;
            status_set[1] = status_q[0];
            state_d       = HIGH;
          end else if (f_only && (state_q == HIGH)) begin
            high_width_d = cnt_inc;
            state_d      = LOW;
          end else if ((counter_q == CNT_MAX) && tick) begin
            status_set[2] = 1'b1;
            counter_d     = '0;
            to_evt        = 1'b1;
            state_d       = IDLE;
          end
        end
        default: begin
          state_d   = IDLE;
          counter_d = '0;
        end
      endcase
    end

    // Hardware set takes priority over a simultaneous write-one-to-clear.
    status_d      = (status_q & ~(status_wr ? dtw[3:0] : 4'd0)) | status_set;
    int_capture_d = cap_evt && cfg_q[3];
    int_timeout_d = to_evt && cfg_q[4];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cfg_q         <= 6'd0;
      period_q      <= '0;
      high_width_q  <= '0;
      counter_q     <= '0;
      status_q      <= 4'd0;
      div_q         <= 10'd0;
      int_capture_q <= 1'b0;
      int_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cfg_q         <= cfg_d;
      period_q      <= period_d;
      high_width_q  <= high_width_d;
      counter_q     <= counter_d;
      status_q      <= status_d;
      div_q         <= div_d;
      int_capture_q <= int_capture_d;
      int_timeout_q <= int_timeout_d;
    end
  end

  assign int_capture = int_capture_q;
  assign int_timeout = int_timeout_q;

  always_comb begin
    dtr = 32'd0;
    case (addr)
      2'd0:    dtr[5:0]          = cfg_q;
      2'd1:    dtr[CAP_BITS-1:0] = period_q;
      2'd2:    dtr[CAP_BITS-1:0] = high_width_q;
      default: dtr[3:0]          = status_q;
    endcase
  end

endmodule
`default_nettype wire
